// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF / EX_MEM stages, the shared memory port and the
// arbiter. The arbiter connects through the slave modport; the surrounding
// pipeline and memory model connect through the master modport.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;

  logic        m_en;
  logic        m_we;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic [63:0] m_rdata;

  logic        busy;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata,
    input  m_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata,
    output m_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data load/store traffic onto the single
// fixed-latency memory port. Data has priority; a streak counter forces a
// fetch grant after MAX_STREAK back-to-back data grants with fetch waiting.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | port free; grant at most one pending requester this cycle
// S_ISSUE | m_en strobe with the registered command
// S_WAIT  | count down the memory latency; capture m_rdata at cnt==0
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned MAX_STREAK = 2
) (
  input logic              clk,
  input logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STR_W = $clog2(MAX_STREAK + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [STR_W-1:0] STR_MAX  = STR_W'(MAX_STREAK);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_fetch_q, owner_fetch_d;
  logic              fetch_live_q, fetch_live_d;
  logic [STR_W-1:0]  streak_q, streak_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [63:0]       d_rdata_q, d_rdata_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic              d_rvalid_q, d_rvalid_d;

  logic              fetch_wins;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              issue;

  // Next-state, arbitration and response capture.
  always_comb begin
    state_d       = state_q;
    owner_fetch_d = owner_fetch_q;
    fetch_live_d  = fetch_live_q;
    streak_d      = streak_q;
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    we_d          = we_q;
    wdata_d       = wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_rvalid_d   = 1'b0;
    d_rvalid_d    = 1'b0;
    if_gnt_c      = 1'b0;
    d_gnt_c       = 1'b0;

    // Fetch only beats a competing data request once the streak saturates.
    fetch_wins = bus.if_req && (!bus.d_req || (streak_q == STR_MAX));

    case (state_q)
      S_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          state_d = S_ISSUE;
          if (fetch_wins) begin
            if_gnt_c      = 1'b1;
            owner_fetch_d = 1'b1;
            // A flush coinciding with the grant already kills this fetch.
            fetch_live_d  = !bus.if_flush;
            addr_d        = bus.if_addr;
            we_d          = 1'b0;
            wdata_d       = '0;
          end else begin
            d_gnt_c       = 1'b1;
            owner_fetch_d = 1'b0;
            fetch_live_d  = 1'b0;
            addr_d        = bus.d_addr;
            we_d          = bus.d_we;
            wdata_d       = bus.d_wdata;
          end
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_INIT;
        if (bus.if_flush) begin
          fetch_live_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (bus.if_flush) begin
          fetch_live_d = 1'b0;
        end
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (owner_fetch_q) begin
            if (fetch_live_q && !bus.if_flush) begin
              if_rvalid_d = 1'b1;
              if_rdata_d  = bus.m_rdata[31:0];
            end
            fetch_live_d = 1'b0;
          end else begin
            // Stores are acknowledged but leave the load data untouched.
            d_rvalid_d = 1'b1;
            if (!we_q) begin
              d_rdata_d = bus.m_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (!bus.if_req || if_gnt_c) begin
      streak_d = '0;
    end else if (d_gnt_c && (streak_q != STR_MAX)) begin
      streak_d = streak_q + STR_W'(1);
    end
  end

  // State and datapath registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_fetch_q <= 1'b0;
      fetch_live_q  <= 1'b0;
      streak_q      <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      we_q          <= 1'b0;
      wdata_q       <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_rvalid_q   <= 1'b0;
      d_rvalid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_fetch_q <= owner_fetch_d;
      fetch_live_q  <= fetch_live_d;
      streak_q      <= streak_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      we_q          <= we_d;
      wdata_q       <= wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_rvalid_q   <= if_rvalid_d;
      d_rvalid_q    <= d_rvalid_d;
    end
  end

  assign issue = (state_q == S_ISSUE);

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.m_en      = issue;
  assign bus.m_we      = issue && we_q;
  assign bus.m_addr    = addr_q;
  assign bus.m_wdata   = issue ? wdata_q : '0;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Instance A (MEM_LAT=1) has a byte
// memory model; B (MEM_LAT=3) and C (MEM_LAT=2) return {~m_addr, m_addr}.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if a_if ();
  mem_port_arbiter_if b_if ();
  mem_port_arbiter_if c_if ();

  mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(2)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  mem_port_arbiter #(.MEM_LAT(3), .MAX_STREAK(2)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave));
  mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(2)) u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

  logic [7:0] mem [logic [31:0]];

  function automatic logic [63:0] rd64(input logic [31:0] a);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (mem.exists(a + 32'(i))) r[8*i +: 8] = mem[a + 32'(i)];
    end
    return r;
  endfunction

  // Memory for instance A: write on the ISSUE cycle, refresh read data every cycle.
  initial a_if.m_rdata = '0;
  always @(negedge clk) begin
    if (a_if.m_en && a_if.m_we) begin
      for (int i = 0; i < 8; i++) mem[a_if.m_addr + 32'(i)] = a_if.m_wdata[8*i +: 8];
    end
    a_if.m_rdata = rd64(a_if.m_addr);
  end

  assign b_if.m_rdata = {~b_if.m_addr, b_if.m_addr};
  assign c_if.m_rdata = {~c_if.m_addr, c_if.m_addr};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int         ngnt;
  int         nfr;
  logic [5:0] seq;

  initial begin
    reset = 1'b1;
    a_if.if_req = 0; a_if.if_addr = 0; a_if.if_flush = 0;
    a_if.d_req = 0; a_if.d_we = 0; a_if.d_addr = 0; a_if.d_wdata = 0;
    b_if.if_req = 0; b_if.if_addr = 0; b_if.if_flush = 0;
    b_if.d_req = 0; b_if.d_we = 0; b_if.d_addr = 0; b_if.d_wdata = 0;
    c_if.if_req = 0; c_if.if_addr = 0; c_if.if_flush = 0;
    c_if.d_req = 0; c_if.d_we = 0; c_if.d_addr = 0; c_if.d_wdata = 0;
    {mem[32'h87], mem[32'h86], mem[32'h85], mem[32'h84]} = 32'h11223344;
    {mem[32'h83], mem[32'h82], mem[32'h81], mem[32'h80]} = 32'h55667788;
    {mem[32'h2003], mem[32'h2002], mem[32'h2001], mem[32'h2000]} = 32'hCAFEF00D;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", a_if.busy, 0);
    chk("rst_m_en", a_if.m_en, 0);
    chk("rst_d_rvalid", a_if.d_rvalid, 0);
    chk("rst_if_rvalid", a_if.if_rvalid, 0);
    reset = 1'b0;

    // Lone load
    step(); a_if.d_req = 1; a_if.d_we = 0; a_if.d_addr = 32'h80; #1;
    chk("load_d_gnt_c0", a_if.d_gnt, 1);
    chk("load_if_gnt_c0", a_if.if_gnt, 0);
    chk("load_busy_c0", a_if.busy, 0);
    step(); a_if.d_req = 0; #1;
    chk("load_m_en_c1", a_if.m_en, 1);
    chk("load_m_we_c1", a_if.m_we, 0);
    chk("load_m_addr_c1", a_if.m_addr, 32'h80);
    chk("load_busy_c1", a_if.busy, 1);
    step(); #1;
    chk("load_m_en_c2", a_if.m_en, 0);
    chk("load_busy_c2", a_if.busy, 1);
    chk("load_rvalid_c2", a_if.d_rvalid, 0);
    step(); #1;
    chk("load_rvalid_c3", a_if.d_rvalid, 1);
    chk("load_rdata_c3", a_if.d_rdata, 64'h1122334455667788);
    chk("load_busy_c3", a_if.busy, 0);
    step(); #1;
    chk("load_rvalid_c4", a_if.d_rvalid, 0);

    // Store then load
    step(); a_if.d_req = 1; a_if.d_we = 1; a_if.d_addr = 32'h100; a_if.d_wdata = 64'hDEADBEEF00000001; #1;
    chk("st_d_gnt", a_if.d_gnt, 1);
    step(); a_if.d_req = 0; #1;
    chk("st_m_en", a_if.m_en, 1);
    chk("st_m_we", a_if.m_we, 1);
    chk("st_m_wdata", a_if.m_wdata, 64'hDEADBEEF00000001);
    step(); #1;
    chk("st_m_wdata_idle", a_if.m_wdata, 0);
    step(); a_if.d_req = 1; a_if.d_we = 0; a_if.d_addr = 32'h100; #1;
    chk("st_rvalid", a_if.d_rvalid, 1);
    chk("st_rdata_kept", a_if.d_rdata, 64'h1122334455667788);
    chk("ld2_gnt_with_rvalid", a_if.d_gnt, 1);
    step(); a_if.d_req = 0;
    step();
    step(); #1;
    chk("ld2_rvalid", a_if.d_rvalid, 1);
    chk("ld2_rdata", a_if.d_rdata, 64'hDEADBEEF00000001);

    // Both requesters held continuously
    step();
    a_if.if_req = 1; a_if.if_addr = 32'h2000;
    a_if.d_req = 1; a_if.d_we = 0; a_if.d_addr = 32'h80;
    ngnt = 0; nfr = 0; seq = '0;
    for (int k = 0; k < 40 && ngnt < 6; k++) begin
      if (k > 0) step();
      #1;
      if (a_if.if_rvalid) begin
        nfr++;
        chk("both_if_rdata", a_if.if_rdata, 32'hCAFEF00D);
      end
      if (a_if.d_gnt) ngnt++;
      else if (a_if.if_gnt) begin
        seq[ngnt] = 1'b1;
        ngnt++;
      end
    end
    chk("both_gnt_count", ngnt, 6);
    chk("both_order", seq, 6'b100100);
    chk("both_if_rvalid_cnt", nfr, 1);
    step(); a_if.if_req = 0; a_if.d_req = 0;
    step();
    step(); #1;
    chk("both_last_if_rvalid", a_if.if_rvalid, 1);
    chk("both_last_if_rdata", a_if.if_rdata, 32'hCAFEF00D);
    step();

    // Flush during WAIT (instance B, MEM_LAT=3)
    step(); b_if.if_req = 1; b_if.if_addr = 32'h40; #1;
    chk("fl_if_gnt_c0", b_if.if_gnt, 1);
    step(); b_if.if_req = 0; b_if.d_req = 1; b_if.d_addr = 32'h8; #1;
    chk("fl_no_gnt_c1", b_if.d_gnt, 0);
    chk("fl_m_en_c1", b_if.m_en, 1);
    step(); b_if.if_flush = 1; #1;
    step(); b_if.if_flush = 0; #1;
    step(); #1;
    chk("fl_busy_c4", b_if.busy, 1);
    step(); #1;
    chk("fl_if_rvalid_c5", b_if.if_rvalid, 0);
    chk("fl_if_rdata_c5", b_if.if_rdata, 0);
    chk("fl_busy_c5", b_if.busy, 0);
    chk("fl_d_gnt_c5", b_if.d_gnt, 1);
    step(); b_if.d_req = 0;
    repeat (4) step();
    #1;
    chk("fl_d_rvalid", b_if.d_rvalid, 1);
    chk("fl_d_rdata", b_if.d_rdata, 64'hFFFFFFF7_00000008);

    // Reset mid-transaction (instance A)
    step(); a_if.d_req = 1; a_if.d_we = 0; a_if.d_addr = 32'h80; #1;
    chk("rm_d_gnt", a_if.d_gnt, 1);
    step(); a_if.d_req = 0; #1;
    chk("rm_m_en_issue", a_if.m_en, 1);
    reset = 1'b1; #1;
    chk("rm_m_en", a_if.m_en, 0);
    chk("rm_busy", a_if.busy, 0);
    chk("rm_m_addr", a_if.m_addr, 0);
    chk("rm_d_rdata", a_if.d_rdata, 0);
    chk("rm_if_rdata", a_if.if_rdata, 0);
    step(); #1;
    chk("rm_d_rvalid_c2", a_if.d_rvalid, 0);
    step(); reset = 1'b0; a_if.d_req = 1; #1;
    chk("rm_d_rvalid_c3", a_if.d_rvalid, 0);
    chk("rm_first_gnt", a_if.d_gnt, 1);
    step(); a_if.d_req = 0; #1;
    chk("rm_d_rvalid_c4", a_if.d_rvalid, 0);
    step();
    step(); #1;
    chk("rm_new_rvalid", a_if.d_rvalid, 1);
    chk("rm_new_rdata", a_if.d_rdata, 64'h1122334455667788);

    // Back-to-back fetches (instance C, MEM_LAT=2)
    step(); c_if.if_req = 1; c_if.if_addr = 32'h400;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      #1;
      chk($sformatf("b2b_if_gnt_c%0d", k), c_if.if_gnt, (k % 4) == 0);
      chk($sformatf("b2b_if_rvalid_c%0d", k), c_if.if_rvalid, (k == 4) || (k == 8) || (k == 12));
      if (k == 12) begin
        chk("b2b_if_rdata", c_if.if_rdata, 32'h400);
        c_if.if_req = 0;
      end
    end
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
